// File: rtl/fetch_pc_unit_if.sv
// Bundle between the fetch unit, instruction memory and decode:
// redirect input, memory request/response and the decode valid/ready register.
interface fetch_pc_unit_if;
  logic        jump_valid;
  logic [31:0] jump_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    input  jump_valid, jump_addr, imem_ack, imem_rdata, out_ready,
    output imem_req, imem_addr, out_valid, out_instr, out_pc
  );

  modport slave (
    output jump_valid, jump_addr, imem_ack, imem_rdata, out_ready,
    input  imem_req, imem_addr, out_valid, out_instr, out_pc
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch front end: owns the PC, fetches from word-addressed memory, squashes on redirect.
// Optional interrupt entry/return is enabled by defining FETCH_IRQ_EN.
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] IRQ_VECTOR = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef FETCH_IRQ_EN
  input  logic        irq,
  input  logic        reti,
  output logic        irq_ack,
  output logic [31:0] epc,
`endif
  fetch_pc_unit_if.master bus
);

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_DISCARD} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        run;
  logic        out_valid_q;
  logic [31:0] out_instr_q;
  logic [31:0] out_pc_q;
  logic        out_free;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic        irq_take;
  logic        req_c;

  assign out_free = !out_valid_q || bus.out_ready;

`ifdef FETCH_IRQ_EN
  logic        in_irq;
  logic [31:0] epc_q;

  // A return from interrupt behaves like a redirect to epc unless a real jump wins.
  assign redirect      = bus.jump_valid || reti;
  assign redirect_addr = bus.jump_valid ? bus.jump_addr : epc_q;
  assign irq_take      = (state == ST_FETCH) && irq && !redirect && out_free && !in_irq;
  assign irq_ack       = irq_take;
  assign epc           = epc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_irq <= 1'b0;
      epc_q  <= 32'h0;
    end else if (irq_take) begin
      in_irq <= 1'b1;
      epc_q  <= pc;
    end else if (reti) begin
      in_irq <= 1'b0;
    end
  end
`else
  assign redirect      = bus.jump_valid;
  assign redirect_addr = bus.jump_addr;
  assign irq_take      = 1'b0;
`endif

  always_comb begin
    req_c = 1'b1;
    if (state == ST_FETCH) begin
      req_c = run && out_free && !redirect && !irq_take;
    end
  end

  assign bus.imem_req  = req_c;
  assign bus.imem_addr = pc;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_pc    = out_pc_q;

  // While a request is outstanding the address must not move, so a redirect
  // during WAIT is parked in pc_next and committed when the stale ack arrives.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_FETCH;
      pc          <= RESET_PC;
      pc_next     <= RESET_PC;
      run         <= 1'b0;
      out_valid_q <= 1'b0;
      out_instr_q <= 32'h0;
      out_pc_q    <= 32'h0;
    end else begin
      run <= 1'b1;

      if (redirect) begin
        out_valid_q <= 1'b0;
      end else if (state == ST_WAIT && bus.imem_ack) begin
        out_valid_q <= 1'b1;
        out_instr_q <= bus.imem_rdata;
        out_pc_q    <= pc;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state)
        ST_FETCH: begin
          if (redirect) begin
            pc <= redirect_addr;
          end else if (irq_take) begin
            pc <= IRQ_VECTOR;
          end else if (req_c) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.imem_ack) begin
            state <= ST_FETCH;
            pc    <= redirect ? redirect_addr : pc + 32'd1;
          end else if (redirect) begin
            pc_next <= redirect_addr;
            state   <= ST_DISCARD;
          end
        end
        ST_DISCARD: begin
          if (bus.imem_ack) begin
            state <= ST_FETCH;
            pc    <= redirect ? redirect_addr : pc_next;
          end else if (redirect) begin
            pc_next <= redirect_addr;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit: directed vector table, multi-cycle corner
// sequences and a randomized run scored against a transaction-level PC model.
module tb_fetch_pc_unit;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] IRQ_VECTOR = 32'h0000_0001;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fetch_pc_unit_if bus ();

`ifdef FETCH_IRQ_EN
  logic        irq;
  logic        reti;
  logic        irq_ack;
  logic [31:0] epc;
`endif

  fetch_pc_unit #(.RESET_PC(RESET_PC), .IRQ_VECTOR(IRQ_VECTOR)) dut (
    .clk     (clk),
    .reset_n (reset_n),
`ifdef FETCH_IRQ_EN
    .irq     (irq),
    .reti    (reti),
    .irq_ack (irq_ack),
    .epc     (epc),
`endif
    .bus     (bus)
  );

  int   errors = 0;
  int   checks = 0;
  int   age = 0;
  int   fixed_lat = 1;
  logic acked = 1'b0;
  logic req_seen = 1'b0;

  typedef struct {
    logic        jv;
    logic [31:0] ja;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] opc;
  } vec_t;

  vec_t vecs[16];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic vec_t mk(input logic jv, input logic [31:0] ja, input logic rdy,
                              input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] opc);
    vec_t v;
    v.jv = jv; v.ja = ja; v.rdy = rdy; v.req = req; v.addr = addr; v.valid = valid; v.opc = opc;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs; the memory answers only after the request has aged.
  task automatic applyStimulus(input logic jv, input logic [31:0] ja, input logic rdy);
    bus.jump_valid = jv;
    bus.jump_addr  = ja;
    bus.out_ready  = rdy;
    bus.imem_ack   = 1'b0;
    #1;
    if (fixed_lat > 0)
      acked = bus.imem_req && (age >= fixed_lat);
    else
      acked = bus.imem_req && (age >= 1) && ((age >= 4) || ($urandom_range(0, 2) == 0));
    bus.imem_ack   = acked;
    bus.imem_rdata = acked ? mem_word(bus.imem_addr) : $urandom;
    #1;
    req_seen = bus.imem_req;
  endtask

  task automatic step();
    @(posedge clk);
    age = (req_seen && !acked) ? age + 1 : 0;
    #1;
  endtask

  task automatic do_reset();
    bus.jump_valid = 1'b0;
    bus.jump_addr  = 32'h0;
    bus.out_ready  = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
`ifdef FETCH_IRQ_EN
    irq  = 1'b0;
    reti = 1'b0;
`endif
    reset_n = 1'b0;
    age = 0;
    acked = 1'b0;
    req_seen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] exp_pc;
    logic        got;
    int          delivered;
    logic        p_pending, p_hold;
    logic [31:0] p_addr, p_pc, p_instr;
    logic        jv, rdy;
    logic [31:0] ja;

    // Reset release, 1-cycle memory, stall, then a redirect coinciding with an ack.
    vecs[0]  = mk(0, 0, 1, 0, 32'h0,   0, 0);
    vecs[1]  = mk(0, 0, 1, 1, 32'h0,   0, 0);
    vecs[2]  = mk(0, 0, 1, 1, 32'h0,   0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 32'h1,   1, 32'h0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h1,   1, 32'h0);
    vecs[5]  = mk(0, 0, 1, 1, 32'h1,   1, 32'h0);
    vecs[6]  = mk(0, 0, 1, 1, 32'h1,   0, 0);
    vecs[7]  = mk(0, 0, 1, 1, 32'h2,   1, 32'h1);
    vecs[8]  = mk(0, 0, 1, 1, 32'h2,   0, 0);
    vecs[9]  = mk(0, 0, 1, 1, 32'h3,   1, 32'h2);
    vecs[10] = mk(0, 0, 1, 1, 32'h3,   0, 0);
    vecs[11] = mk(0, 0, 1, 1, 32'h4,   1, 32'h3);
    vecs[12] = mk(1, 32'h100, 1, 1, 32'h4, 0, 0);
    vecs[13] = mk(0, 0, 1, 1, 32'h100, 0, 0);
    vecs[14] = mk(0, 0, 1, 1, 32'h100, 0, 0);
    vecs[15] = mk(0, 0, 1, 1, 32'h101, 1, 32'h100);

    fixed_lat = 1;
    do_reset();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].jv, vecs[i].ja, vecs[i].rdy);
      checkOutput($sformatf("vec%0d_req", i), 32'(bus.imem_req), 32'(vecs[i].req));
      checkOutput($sformatf("vec%0d_addr", i), bus.imem_addr, vecs[i].addr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'(vecs[i].valid));
      if (vecs[i].valid) begin
        checkOutput($sformatf("vec%0d_pc", i), bus.out_pc, vecs[i].opc);
        checkOutput($sformatf("vec%0d_instr", i), bus.out_instr, mem_word(vecs[i].opc));
      end
      step();
    end

    // Redirect during WAIT with a slow memory: old address held until the stale ack.
    fixed_lat = 3;
    do_reset();
    applyStimulus(0, 0, 1); step();
    applyStimulus(0, 0, 1);
    checkOutput("disc_issue_req", 32'(bus.imem_req), 32'd1);
    step();
    applyStimulus(1, 32'h100, 1);
    checkOutput("disc_redir_addr", bus.imem_addr, 32'h0);
    step();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 0, 1);
      checkOutput($sformatf("disc_hold_req%0d", i), 32'(bus.imem_req), 32'd1);
      checkOutput($sformatf("disc_hold_addr%0d", i), bus.imem_addr, 32'h0);
      checkOutput($sformatf("disc_hold_valid%0d", i), 32'(bus.out_valid), 32'd0);
      step();
    end
    applyStimulus(0, 0, 1);
    checkOutput("disc_new_addr", bus.imem_addr, 32'h100);
    checkOutput("disc_new_req", 32'(bus.imem_req), 32'd1);
    checkOutput("disc_new_valid", 32'(bus.out_valid), 32'd0);
    step();
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      applyStimulus(0, 0, 1);
      if (bus.out_valid) got = 1'b1;
      else step();
    end
    checkOutput("disc_first_out", 32'(got), 32'd1);
    checkOutput("disc_out_pc", bus.out_pc, 32'h100);
    checkOutput("disc_out_instr", bus.out_instr, mem_word(32'h100));
    step();

    // PC wrap at the top of the address space.
    fixed_lat = 1;
    do_reset();
    applyStimulus(1, 32'hFFFF_FFFF, 1); step();
    applyStimulus(0, 0, 1);
    checkOutput("wrap_req_addr", bus.imem_addr, 32'hFFFF_FFFF);
    step();
    applyStimulus(0, 0, 1); step();
    applyStimulus(0, 0, 1);
    checkOutput("wrap_out_pc", bus.out_pc, 32'hFFFF_FFFF);
    checkOutput("wrap_out_instr", bus.out_instr, mem_word(32'hFFFF_FFFF));
    checkOutput("wrap_next_addr", bus.imem_addr, 32'h0);
    checkOutput("wrap_next_req", 32'(bus.imem_req), 32'd1);
    step();

    // Asynchronous reset in the middle of an outstanding request.
    fixed_lat = 3;
    applyStimulus(0, 0, 1);
    reset_n = 1'b0;
    #1;
    checkOutput("midrst_req", 32'(bus.imem_req), 32'd0);
    checkOutput("midrst_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_addr", bus.imem_addr, RESET_PC);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    age = 0;
    applyStimulus(0, 0, 1);
    checkOutput("midrst_norun_req", 32'(bus.imem_req), 32'd0);
    step();
    applyStimulus(0, 0, 1);
    checkOutput("midrst_run_req", 32'(bus.imem_req), 32'd1);
    checkOutput("midrst_run_addr", bus.imem_addr, RESET_PC);
    step();

`ifdef FETCH_IRQ_EN
    // Interrupt entry at pc 0x20, ignored second request, then return.
    fixed_lat = 1;
    do_reset();
    applyStimulus(1, 32'h20, 1); step();
    irq = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("irq_ack_pulse", 32'(irq_ack), 32'd1);
    checkOutput("irq_no_req", 32'(bus.imem_req), 32'd0);
    step();
    applyStimulus(0, 0, 1);
    checkOutput("irq_ack_once", 32'(irq_ack), 32'd0);
    checkOutput("irq_epc", epc, 32'h20);
    checkOutput("irq_vec_addr", bus.imem_addr, IRQ_VECTOR);
    step();
    applyStimulus(0, 0, 1);
    checkOutput("irq_nested_ignored", 32'(irq_ack), 32'd0);
    step();
    irq  = 1'b0;
    reti = 1'b1;
    applyStimulus(0, 0, 1);
    checkOutput("reti_out_pc", bus.out_pc, IRQ_VECTOR);
    checkOutput("reti_no_req", 32'(bus.imem_req), 32'd0);
    step();
    reti = 1'b0;
    applyStimulus(0, 0, 1);
    checkOutput("reti_addr", bus.imem_addr, 32'h20);
    checkOutput("reti_req", 32'(bus.imem_req), 32'd1);
    checkOutput("reti_squash", 32'(bus.out_valid), 32'd0);
    step();
`endif

    // Randomized run against a transaction-level model of the delivered PC stream.
    fixed_lat = 0;
    do_reset();
    exp_pc = RESET_PC;
    delivered = 0;
    p_pending = 1'b0;
    p_hold = 1'b0;
    p_addr = 0; p_pc = 0; p_instr = 0;
    for (int c = 0; c < 3000; c++) begin
      jv  = ($urandom_range(0, 99) < 6);
      ja  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)))
                                        : 32'($urandom_range(0, 65535));
      rdy = ($urandom_range(0, 99) < 70);
      applyStimulus(jv, ja, rdy);
      if (p_pending) begin
        checkOutput("rnd_req_held", 32'(bus.imem_req), 32'd1);
        checkOutput("rnd_addr_stable", bus.imem_addr, p_addr);
      end
      if (p_hold) begin
        checkOutput("rnd_valid_held", 32'(bus.out_valid), 32'd1);
        checkOutput("rnd_pc_held", bus.out_pc, p_pc);
        checkOutput("rnd_instr_held", bus.out_instr, p_instr);
      end
      if (bus.out_valid && rdy && !jv) begin
        checkOutput("rnd_out_pc", bus.out_pc, exp_pc);
        checkOutput("rnd_out_instr", bus.out_instr, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd1;
        delivered++;
      end
      if (jv) exp_pc = ja;
      p_pending = bus.imem_req && !acked;
      p_addr    = bus.imem_addr;
      p_hold    = bus.out_valid && !rdy && !jv;
      p_pc      = bus.out_pc;
      p_instr   = bus.out_instr;
      step();
    end
    checkOutput("rnd_progress", 32'(delivered > 100), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
